stream_width_pack: RTL and testbench



---
 rtl/stream_pkg.sv | 25 ++
 rtl/stream_width_pack_if.sv | 30 +++
 rtl/stream_width_pack.sv | 151 +++++++++++++++
 tb/tb_stream_width_pack.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the camera-to-DMA width packer.
// STREAM_PACK_BYTESWAP_EN (see stream_width_pack) does not affect anything here.
package stream_pkg;

  localparam int PIX_WIDTH = 16;
  localparam int DMA_WIDTH = 128;
  localparam int LANES     = DMA_WIDTH / PIX_WIDTH;

  // One bit per pixel lane of a DMA word.
  typedef logic [LANES-1:0] lane_mask_t;

  // Elaboration-time ceil(log2(value)).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_width_pack_if.sv
// Valid/ready stream bundles: narrow pixel beats in, wide lane-masked words out.
interface pix_stream_if
  import stream_pkg::*;
#(
  parameter int W = PIX_WIDTH
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;
  logic         last;

  modport master (output valid, output payload, output last, input ready);
  modport slave  (input valid, input payload, input last, output ready);
endinterface

interface word_stream_if
  import stream_pkg::*;
#(
  parameter int W = DMA_WIDTH,
  parameter int L = LANES
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;
  logic         last;
  logic [L-1:0] keep;

  modport master (output valid, output payload, output last, output keep, input ready);
  modport slave  (input valid, input payload, input last, input keep, output ready);
endinterface

// File: rtl/stream_width_pack.sv
// Packs IN_WIDTH pixel beats into OUT_WIDTH words; `last` flushes a zero-padded partial word.
// Build option: define STREAM_PACK_BYTESWAP_EN to byte-reverse each beat before lane insertion.
module stream_width_pack
  import stream_pkg::*;
#(
  parameter int IN_WIDTH  = PIX_WIDTH,
  parameter int OUT_WIDTH = DMA_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  pix_stream_if.slave   dataIn,
  word_stream_if.master dataOut
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = clog2(RATIO);

  typedef logic [RATIO-1:0] keep_t;

  logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  keep_t                acc_keep_q, acc_keep_d;
  logic                 acc_last_q, acc_last_d;
  logic                 acc_full_q, acc_full_d;
  logic [OUT_WIDTH-1:0] out_payload_q, out_payload_d;
  keep_t                out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;

  logic [IN_WIDTH-1:0]  beat_data;
  logic [OUT_WIDTH-1:0] acc_merged;
  keep_t                keep_merged;
  logic                 in_fire;
  logic                 out_free;
  logic                 word_done;

`ifdef STREAM_PACK_BYTESWAP_EN
  localparam int BYTES = IN_WIDTH / 8;

  // Sensor sends high byte first; DMA side expects little-endian lanes.
  always_comb begin
    beat_data = '0;
    for (int b = 0; b < BYTES; b++) begin
      beat_data[b*8 +: 8] = dataIn.payload[(BYTES-1-b)*8 +: 8];
    end
  end
`else
  assign beat_data = dataIn.payload;
`endif

  // Accumulator with the incoming beat dropped into lane lane_cnt.
  always_comb begin
    acc_merged  = acc_q;
    keep_merged = acc_keep_q;
    for (int l = 0; l < RATIO; l++) begin
      if (lane_cnt_q == LANE_W'(l)) begin
        acc_merged[l*IN_WIDTH +: IN_WIDTH] = beat_data;
        keep_merged[l]                     = 1'b1;
      end
    end
  end

  assign in_fire   = dataIn.valid && !acc_full_q;
  assign out_free  = !out_valid_q || dataOut.ready;
  assign word_done = in_fire && ((lane_cnt_q == LANE_W'(RATIO - 1)) || dataIn.last);

  always_comb begin
    // NOTE: every *_d starts from its current value, so no branch leaves one unassigned and no latch is inferred.
    lane_cnt_d    = lane_cnt_q;
    acc_d         = acc_q;
    acc_keep_d    = acc_keep_q;
    acc_last_d    = acc_last_q;
    acc_full_d    = acc_full_q;
    out_payload_d = out_payload_q;
    out_keep_d    = out_keep_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q;

    if (out_valid_q && dataOut.ready) begin
      out_valid_d = 1'b0;
    end

    if (acc_full_q) begin
      // A parked word leaves as soon as the output register frees up.
      if (out_free) begin
        out_payload_d = acc_q;
        out_keep_d    = acc_keep_q;
        out_last_d    = acc_last_q;
        out_valid_d   = 1'b1;
        acc_d         = '0;
        acc_keep_d    = '0;
        acc_last_d    = 1'b0;
        acc_full_d    = 1'b0;
        lane_cnt_d    = '0;
      end
    end else if (in_fire) begin
      if (word_done && out_free) begin
        out_payload_d = acc_merged;
        out_keep_d    = keep_merged;
        out_last_d    = dataIn.last;
        out_valid_d   = 1'b1;
        acc_d         = '0;
        acc_keep_d    = '0;
        acc_last_d    = 1'b0;
        lane_cnt_d    = '0;
      end else if (word_done) begin
        acc_d      = acc_merged;
        acc_keep_d = keep_merged;
        acc_last_d = dataIn.last;
        acc_full_d = 1'b1;
      end else begin
        acc_d      = acc_merged;
        acc_keep_d = keep_merged;
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
      end
    end
  end

  // NOTE: the accumulator is plain flops rather than a RAM, so it may take the async reset like everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_cnt_q    <= '0;
      acc_q         <= '0;
      acc_keep_q    <= '0;
      acc_last_q    <= 1'b0;
      acc_full_q    <= 1'b0;
      out_payload_q <= '0;
      out_keep_q    <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      lane_cnt_q    <= lane_cnt_d;
      acc_q         <= acc_d;
      acc_keep_q    <= acc_keep_d;
      acc_last_q    <= acc_last_d;
      acc_full_q    <= acc_full_d;
      out_payload_q <= out_payload_d;
      out_keep_q    <= out_keep_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign dataIn.ready    = !acc_full_q;
  assign dataOut.valid   = out_valid_q;
  assign dataOut.payload = out_payload_q;
  assign dataOut.keep    = out_keep_q;
  assign dataOut.last    = out_last_q;

endmodule

// File: tb/tb_stream_width_pack.sv
// Self-checking bench for stream_width_pack: directed scenarios plus randomized traffic
// checked against a queue-based packing model.
module tb_stream_width_pack;
  import stream_pkg::*;

  localparam int IW = PIX_WIDTH;
  localparam int OW = DMA_WIDTH;
  localparam int R  = OW / IW;

  typedef struct {
    logic [OW-1:0] payload;
    lane_mask_t    keep;
    logic          last;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pix_stream_if  #(.W(IW))         in_if ();
  word_stream_if #(.W(OW), .L(R))  out_if ();

  stream_width_pack #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .dataIn  (in_if),
    .dataOut (out_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [IW-1:0] part_q[$];
  word_t         exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] swp(input logic [IW-1:0] x);
    logic [IW-1:0] r;
`ifdef STREAM_PACK_BYTESWAP_EN
    for (int b = 0; b < IW/8; b++) r[b*8 +: 8] = x[(IW/8-1-b)*8 +: 8];
`else
    r = x;
`endif
    return r;
  endfunction

  // Reference: a word is the beats collected so far, lane i = i-th beat, rest zero.
  function automatic word_t build(input logic last);
    word_t w;
    w.payload = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      w.payload = w.payload | (OW'(swp(part_q[i])) << (i*IW));
    end
    w.keep = lane_mask_t'((1 << part_q.size()) - 1);
    w.last = last;
    return w;
  endfunction

  // Input-side model: handshakes seen at negedge complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      part_q.delete();
      exp_q.delete();
    end else if (in_if.valid && in_if.ready) begin
      part_q.push_back(in_if.payload);
      if (part_q.size() == R || in_if.last) begin
        exp_q.push_back(build(in_if.last));
        part_q.delete();
      end
    end
  end

  // Output-side scoreboard plus the "ready only drops while the output is full" rule.
  always @(negedge clk) begin
    word_t w;
    if (rst_n) begin
      if (!in_if.ready) check("ready_low_needs_out_valid", out_if.valid, 1'b1);
      if (out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1'b1, 1'b0);
        end else begin
          w = exp_q.pop_front();
          check("word_payload", out_if.payload, w.payload);
          check("word_keep", out_if.keep, w.keep);
          check("word_last", out_if.last, w.last);
        end
      end
    end
  end

  task automatic send_beat(input logic [IW-1:0] d, input logic l);
    int waited;
    waited          = 0;
    in_if.valid     = 1'b1;
    in_if.payload   = d;
    in_if.last      = l;
    forever begin
      @(negedge clk);
      if (in_if.ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    bit  done;
    logic [OW-1:0] e;

    in_if.valid   = 1'b0;
    in_if.payload = '0;
    in_if.last    = 1'b0;
    out_if.ready  = 1'b1;

    // Reset values
    @(posedge clk);
    #1;
    check("rst_out_valid", out_if.valid, 1'b0);
    check("rst_out_last", out_if.last, 1'b0);
    check("rst_out_keep", out_if.keep, '0);
    check("rst_out_payload", out_if.payload, '0);
    check("rst_in_ready", in_if.ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Eight beats 1..8 -> one full word, latency 1
    t0 = cyc;
    for (int i = 1; i <= R; i++) begin
      if (i == R) check("full_valid_before_8th", out_if.valid, 1'b0);
      send_beat(IW'(i), 1'b0);
    end
    check("full_cycles", OW'(cyc - t0), OW'(R));
    check("full_valid", out_if.valid, 1'b1);
`ifdef STREAM_PACK_BYTESWAP_EN
    check("full_payload", out_if.payload, 128'h0800_0700_0600_0500_0400_0300_0200_0100);
`else
    check("full_payload", out_if.payload, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
`endif
    check("full_keep", out_if.keep, 8'hFF);
    check("full_last", out_if.last, 1'b0);

    // Short word terminated by last
    send_beat(16'hAAAA, 1'b0);
    send_beat(16'hBBBB, 1'b0);
    send_beat(16'hCCCC, 1'b1);
    check("short_payload", out_if.payload, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    check("short_keep", out_if.keep, 8'h07);
    check("short_last", out_if.last, 1'b1);

    // 64 beats with a 20-cycle downstream stall mid-stream
    fork
      begin
        for (int i = 0; i < 64; i++) send_beat(IW'(16'h1000 + i), 1'b0);
      end
      begin
        repeat (20) @(posedge clk);
        #2 out_if.ready = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("stall_in_ready_low", in_if.ready, 1'b0);
        check("stall_out_valid", out_if.valid, 1'b1);
        out_if.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall_ready_returns", in_if.ready, 1'b1);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Last on lane 0 while the output is stalled
    out_if.ready = 1'b0;
    for (int i = 0; i < R; i++) send_beat(IW'(16'h2000 + i), 1'b0);
    send_beat(16'h3C01, 1'b1);
    check("lane0_in_ready", in_if.ready, 1'b0);
    check("lane0_first_keep", out_if.keep, 8'hFF);
    out_if.ready = 1'b1;
    @(posedge clk);
    #1;
    check("lane0_second_valid", out_if.valid, 1'b1);
    check("lane0_second_keep", out_if.keep, 8'h01);
    check("lane0_second_last", out_if.last, 1'b1);
    check("lane0_second_payload", out_if.payload, OW'(swp(16'h3C01)));
    @(negedge clk);
    check("lane0_ready_back", in_if.ready, 1'b1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-word
    for (int i = 0; i < 5; i++) send_beat(IW'(16'h7700 + i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_if.valid, 1'b0);
    check("mid_rst_in_ready", in_if.ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", out_if.valid, 1'b0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < R; i++) send_beat(IW'(16'h4000 + i), 1'b0);
    check("post_rst_keep", out_if.keep, 8'hFF);
    check("post_rst_valid", out_if.valid, 1'b1);

    // Byte order of a repeated pixel
    for (int i = 0; i < R; i++) send_beat(16'h1234, 1'b0);
`ifdef STREAM_PACK_BYTESWAP_EN
    e = {R{16'h3412}};
`else
    e = {R{16'h1234}};
`endif
    check("swap_payload", out_if.payload, e);

    // Randomized traffic with random back-pressure and random last
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int gap;
          gap = $urandom_range(0, 2);
          if (gap != 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          send_beat(IW'($urandom), ($urandom_range(0, 9) == 0));
        end
        send_beat(IW'($urandom), 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_if.ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_if.ready = 1'b1;

    // Drain and confirm nothing was lost or duplicated
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_if.valid) break;
    end
    check("drain_exp_empty", OW'(exp_q.size()), '0);
    check("drain_part_empty", OW'(part_q.size()), '0);
    check("drain_out_idle", out_if.valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
